// File: rtl/id_scoreboard_pkg.sv
// Shared types and constants for the decode-stage issue scoreboard.
// Holds the drain FSM encoding and the fixed pipeline latencies.
package id_scoreboard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } sb_state_t;

    localparam logic [2:0] LAT_ALU  = 3'd3;
    localparam logic [2:0] LAT_LOAD = 3'd3;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_scoreboard_sb_entry.sv
// One register's countdown: cycles left until its in-flight writer reaches the heap.
// Clear beats load, and load beats the automatic decrement.
module sb_entry
    import id_scoreboard_pkg::*;
#(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [LAT_W-1:0] ld_val,
    output logic [LAT_W-1:0] cnt,
    output logic             nonzero
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign nonzero = (cnt != '0);

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage scoreboard: per-register countdowns, operand hazard stall,
// RUN/DRAIN/HALTED quiesce handshake and a saturating stall-cycle counter.
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int LAT_W    = 3,
    parameter int READY_AT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wen,
    input  logic [4:0]       id_rd,
    input  logic [LAT_W-1:0] id_lat,
    input  logic             flush,
    input  logic             flush_all,
    input  logic             drain_req,
    output logic             stall,
    output logic             issue,
    output logic             drain_ack,
    output logic             busy_any,
    output logic [15:0]      stall_cnt
);

    localparam logic [LAT_W-1:0] READY_LIM = LAT_W'(READY_AT);

    sb_state_t        state;
    logic [LAT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  nonzero;
    logic             rs_busy;
    logic             rt_busy;

    // Register 0 never holds a pending write, so it has no entry.
    assign cnt[0]     = '0;
    assign nonzero[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_entry
        sb_entry #(.LAT_W(LAT_W)) u_entry (
            .clk     (clk),
            .rst     (rst),
            .clr     (flush_all),
            .ld      (issue && id_wen && (id_rd == 5'(i))),
            .ld_val  (id_lat),
            .cnt     (cnt[i]),
            .nonzero (nonzero[i])
        );
    end

    // Hazard compares the pre-update counters, so rs==rd in one instruction never stalls.
    always_comb begin
        rs_busy = id_use_rs && (id_rs != REG_ZERO) && (cnt[id_rs] > READY_LIM);
        rt_busy = id_use_rt && (id_rt != REG_ZERO) && (cnt[id_rt] > READY_LIM);
    end

    assign busy_any  = |nonzero;
    assign stall     = id_valid && (rs_busy || rt_busy || (state != RUN));
    assign issue     = id_valid && !stall && !flush && !flush_all;
    assign drain_ack = (state == HALTED);

    // A dropped drain request wins over completion while draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (drain_req) state <= DRAIN;
                DRAIN:   if (!drain_req) state <= RUN;
                         else if (!busy_any) state <= HALTED;
                HALTED:  if (!drain_req) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed and random stimulus for id_scoreboard against a per-register
// countdown reference model; every comparison is an immediate assertion.
module tb_id_scoreboard;
    import id_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_rs, id_use_rt, id_wen;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [2:0]  id_lat;
    logic        flush, flush_all, drain_req;
    logic        stall, issue, drain_ack, busy_any;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remaining cycles per register, drain mode, stall count.
    int mcnt [32];
    int mmode;
    int mstalls;

    always #5 clk = ~clk;

    id_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_wen    (id_wen),
        .id_rd     (id_rd),
        .id_lat    (id_lat),
        .flush     (flush),
        .flush_all (flush_all),
        .drain_req (drain_req),
        .stall     (stall),
        .issue     (issue),
        .drain_ack (drain_ack),
        .busy_any  (busy_any),
        .stall_cnt (stall_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit src_waiting(input logic use_r, input logic [4:0] r);
        return use_r && (r != 5'd0) && (mcnt[r] > 1);
    endfunction

    function automatic bit model_stall();
        return id_valid && (src_waiting(id_use_rs, id_rs) || src_waiting(id_use_rt, id_rt) || mmode != 0);
    endfunction

    function automatic bit model_busy();
        for (int i = 0; i < 32; i++) if (mcnt[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mcnt[i] = 0;
        mmode   = 0;
        mstalls = 0;
    endtask

    task automatic drive(input logic v, input int rs_i, input int rt_i, input logic urs, input logic urt,
                         input logic wen, input int rd_i, input int lat_i,
                         input logic fl, input logic fla, input logic dr, input logic r);
        id_valid  = v;
        id_rs     = 5'(rs_i);
        id_rt     = 5'(rt_i);
        id_use_rs = urs;
        id_use_rt = urt;
        id_wen    = wen;
        id_rd     = 5'(rd_i);
        id_lat    = 3'(lat_i);
        flush     = fl;
        flush_all = fla;
        drain_req = dr;
        rst       = r;
    endtask

    // Compare outputs mid-cycle, advance the model, then cross one rising edge.
    task automatic tick();
        bit exp_stall, exp_issue, exp_busy;
        @(negedge clk);
        exp_stall = model_stall();
        exp_issue = id_valid && !exp_stall && !flush && !flush_all;
        exp_busy  = model_busy();
        checkOutput("stall", stall, exp_stall);
        checkOutput("issue", issue, exp_issue);
        checkOutput("busy_any", busy_any, exp_busy);
        checkOutput("drain_ack", drain_ack, mmode == 2);
        checkOutput("stall_cnt", stall_cnt, mstalls);
        if (rst) begin
            model_reset();
        end else begin
            if (exp_stall && mstalls < 65535) mstalls++;
            if (mmode == 0 && drain_req) mmode = 1;
            else if (mmode == 1 && !drain_req) mmode = 0;
            else if (mmode == 1 && !exp_busy) mmode = 2;
            else if (mmode == 2 && !drain_req) mmode = 0;
            for (int i = 0; i < 32; i++) begin
                if (flush_all) mcnt[i] = 0;
                else if (mcnt[i] > 0) mcnt[i]--;
            end
            if (exp_issue && id_wen && id_rd != 5'd0) mcnt[id_rd] = id_lat;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input int rs_i, input int rt_i, input logic urs, input logic urt,
                                 input logic wen, input int rd_i, input int lat_i,
                                 input logic fl, input logic fla, input logic dr, input logic r);
        drive(v, rs_i, rt_i, urs, urt, wen, rd_i, lat_i, fl, fla, dr, r);
        tick();
    endtask

    initial begin
        int dr_level;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        $display("[TB] reset state");
        applyStimulus(1, 3, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_busy", busy_any, 0);
        checkOutput("rst_stall_cnt", stall_cnt, 0);
        checkOutput("rst_drain_ack", drain_ack, 0);

        $display("[TB] back-to-back dependency");
        applyStimulus(1, 0, 0, 0, 0, 1, 3, int'(LAT_ALU), 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) applyStimulus(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("b2b_stall_cnt", stall_cnt, 2);

        $display("[TB] zero register and unused source");
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0);
        checkOutput("rd0_busy", busy_any, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 5, 3, 0, 0, 0, 0);
        drive(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("unused_rt_stall", stall, 0);
        tick();

        $display("[TB] WAW override");
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 3, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0);
        drive(1, 7, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("waw_stall", stall, 0);
        tick();

        $display("[TB] flush interactions");
        applyStimulus(1, 0, 0, 0, 0, 1, 4, 5, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 4, 1, 1, 0, 0, 0);
        #1;
        checkOutput("flush_issue", issue, 0);
        tick();
        drive(1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("flush_keeps_r4", stall, 1);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 1, 8, 6, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 9, 6, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("flush_all_busy", busy_any, 0);

        $display("[TB] drain handshake");
        applyStimulus(1, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0);
        applyStimulus(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
            #1;
            checkOutput("drain_stall", stall, 1);
            checkOutput("drain_ack_early", drain_ack, 0);
            tick();
        end
        checkOutput("drain_ack_edge4", drain_ack, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("drain_release", drain_ack, 0);

        $display("[TB] reset mid-drain");
        applyStimulus(1, 0, 0, 0, 0, 1, 11, 7, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 12, 5, 0, 0, 1, 0);
        applyStimulus(1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        checkOutput("rst_pending_busy", busy_any, 1);
        tick();
        drive(1, 11, 12, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        #1;
        checkOutput("post_rst_busy", busy_any, 0);
        checkOutput("post_rst_stall_cnt", stall_cnt, 0);
        checkOutput("post_rst_drain_ack", drain_ack, 0);
        checkOutput("post_rst_stall", stall, 0);
        tick();

        $display("[TB] random phase");
        dr_level = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 19) == 0) dr_level = 1 - dr_level;
            applyStimulus(1'($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)),
                          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 29) == 0),
                          1'(dr_level), 1'($urandom_range(0, 99) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Issue-control scheduler for the decode stage of the 5-stage R/I/J pipeline.
- Tracks, per architectural register, how many cycles remain until an in-flight writer's result reaches the register heap.
- Raises a stall to hold the decode stage while a source operand is not yet readable.
- Provides a drain handshake (RUN/DRAIN/HALTED) so the core can quiesce before halting or taking an exception.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- LAT_W, 3, width of each per-register countdown counter; maximum latency is 2^LAT_W-1.
- READY_AT, 1, a source is readable when its counter is less than or equal to this value. With 1, the write-back-cycle value is readable because the register heap writes on the falling edge.

Ports:
- clk  in  1  Clock. All state updates on the rising edge.
- rst  in  1  Reset, synchronous, active-high.
- id_valid  in  1  Decode stage holds a valid instruction this cycle.
- id_rs  in  5  Source register A address (IR[25:21]).
- id_rt  in  5  Source register B address (IR[20:16]).
- id_use_rs  in  1  Instruction reads rs.
- id_use_rt  in  1  Instruction reads rt.
- id_wen  in  1  Instruction writes a register.
- id_rd  in  5  Destination register address.
- id_lat  in  LAT_W  Cycles from issue until the write-back cycle (3 for ALU ops in this pipeline, 3 for loads).
- flush  in  1  Squash the decode-stage instruction this cycle; it does not issue.
- flush_all  in  1  Exception/redirect: discard all in-flight bookkeeping.
- drain_req  in  1  Request to quiesce; level-sensitive.
- stall  out  1  Hold IF/ID this cycle; combinational from state and inputs.
- issue  out  1  Decode instruction is accepted this cycle.
- drain_ack  out  1  High while in HALTED.
- busy_any  out  1  At least one counter is nonzero.
- stall_cnt  out  16  Saturating count of stall cycles, for performance monitoring.

Behaviour:
- Reset state (rst high at a rising edge): all counters 0, FSM in RUN, stall_cnt 0.
- Reset-time outputs: stall 0 (it depends only on state plus id_valid), issue 0 unless id_valid, drain_ack 0, busy_any 0.
- Hazard condition: haz = id_valid AND ((id_use_rs AND id_rs!=0 AND cnt[id_rs]>READY_AT) OR (id_use_rt AND id_rt!=0 AND cnt[id_rt]>READY_AT)).
- stall = haz OR (id_valid AND state!=RUN).
- issue = id_valid AND NOT stall AND NOT flush AND NOT flush_all.
- Per-cycle counter update, in priority order:
  1. flush_all: all counters cleared to 0.
  2. Otherwise, every nonzero counter decrements by 1.
  3. If issue AND id_wen AND id_rd!=0, then cnt[id_rd] is loaded with id_lat. The load overrides the decrement; a WAW write from a younger instruction replaces the older value.
- id_lat = 0 is treated as no tracking: the counter is written 0.
- Register 0 is never marked busy; writes to rd=0 are ignored.
- Simultaneous issue-write and source read of the same register: the hazard check uses the pre-update counter. Same-cycle self-dependence (rs==rd) does not stall.
- FSM:
  - RUN -> DRAIN when drain_req=1.
  - DRAIN -> HALTED when busy_any=0. A single cycle is possible if already idle: RUN->DRAIN at edge n, HALTED at edge n+1.
  - HALTED -> RUN when drain_req=0.
  - DRAIN -> RUN if drain_req drops before empty.
  - flush_all does not change FSM state. It clears the counters, so DRAIN completes on the next edge.
- stall_cnt increments on each cycle with stall=1 and saturates at 16'hFFFF. It is cleared only by rst.
- Reset asserted mid-drain or mid-countdown returns everything to the reset state at that edge; there are no partial effects.

Decomposition:
- Shared package:
  - FSM state encoding: RUN=2'd0, DRAIN=2'd1, HALTED=2'd2.
  - Latency constants: LAT_ALU=3, LAT_LOAD=3.
  - REG_ZERO=5'd0.
- One natural sub-module, sb_entry: a single register's counter holding clr, ld, ld_val, and auto-decrement logic, with a nonzero flag. It is instantiated NREG-1 times. The top holds the hazard compare, the FSM and the stall counter.

Test Plan:
- Back-to-back dependency:
  - Stimulus: issue "add r3" with lat=3; next cycle the instruction reads rs=3.
  - Required response: stall=1 for exactly 2 cycles (cnt 3->2->1); issues on the third cycle; stall_cnt=2.
- Zero register and unused sources:
  - Stimulus: write rd=0 with lat=3, then read rs=0. Separately, read rt=5 with cnt[5]=3 but id_use_rt=0.
  - Required response: no stall in either case; busy_any stays 0 after the rd=0 write.
- WAW override:
  - Stimulus: issue r7 with lat=3; next cycle issue r7 with lat=1.
  - Required response: cnt[7]=1; a reader of r7 in the following cycle does not stall.
- Flush interaction:
  - Stimulus: id_valid with id_wen, rd=4, flush=1.
  - Required response: issue=0, cnt[4] unchanged.
  - Stimulus: flush_all while three counters are nonzero.
  - Required response: busy_any=0 on the next cycle.
- Drain handshake:
  - Stimulus: cnt[2]=3, assert drain_req.
  - Required response: DRAIN for 3 cycles with stall=1 for valid instructions; drain_ack rises on the 4th edge; deasserting drain_req returns to RUN with drain_ack=0 next cycle.
- Synchronous reset mid-operation:
  - Stimulus: rst pulsed for one cycle during DRAIN with counters nonzero.
  - Required response: the next cycle shows RUN, busy_any=0, stall_cnt=0, drain_ack=0. Asserting rst between edges has no effect until the rising edge.
